bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader_if.sv | 42 ++++
 rtl/bram_stream_reader.sv | 141 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Signal bundle between bram_stream_reader and its surroundings (control, RAM read port, stream).
// m_last_o is present only when BRAM_STREAM_READER_LAST_EN is defined.
interface bram_stream_reader_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8
);
   logic                     start_i;
   logic [ADDRESS_WIDTH-1:0] base_address_i;
   logic [ADDRESS_WIDTH:0]   length_i;
   logic                     busy_o;
   logic                     done_o;
   logic [ADDRESS_WIDTH-1:0] rd_address_o;
   logic                     rd_enable_o;
   logic [DATA_WIDTH-1:0]    rd_data_i;
   logic                     rd_valid_i;
   logic [DATA_WIDTH-1:0]    m_data_o;
   logic                     m_valid_o;
   logic                     m_ready_i;
`ifdef BRAM_STREAM_READER_LAST_EN
   logic                     m_last_o;

   modport slave (
      input  start_i, base_address_i, length_i, rd_data_i, rd_valid_i, m_ready_i,
      output busy_o, done_o, rd_address_o, rd_enable_o, m_data_o, m_valid_o, m_last_o
   );

   modport master (
      output start_i, base_address_i, length_i, rd_data_i, rd_valid_i, m_ready_i,
      input  busy_o, done_o, rd_address_o, rd_enable_o, m_data_o, m_valid_o, m_last_o
   );
`else
   modport slave (
      input  start_i, base_address_i, length_i, rd_data_i, rd_valid_i, m_ready_i,
      output busy_o, done_o, rd_address_o, rd_enable_o, m_data_o, m_valid_o
   );

   modport master (
      output start_i, base_address_i, length_i, rd_data_i, rd_valid_i, m_ready_i,
      input  busy_o, done_o, rd_address_o, rd_enable_o, m_data_o, m_valid_o
   );
`endif
endinterface

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a 1-cycle-latency block RAM into a 2-entry buffer and streams them out.
// Optional macro BRAM_STREAM_READER_LAST_EN adds m_last_o on the final word of each burst.
module bram_stream_reader #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   bram_stream_reader_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                   state_reg, state_next;
   logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
   logic [ADDRESS_WIDTH:0]   reads_left_reg, reads_left_next;
   logic [ADDRESS_WIDTH:0]   words_left_reg, words_left_next;
   logic                     done_reg, done_next;
   logic                     in_flight_reg;
   logic [1:0]               count_reg, count_next;
   logic                     head_reg, head_next;
   logic                     tail_reg, tail_next;
   logic                     m_valid_reg, m_valid_next;

   logic                     pop;
   logic                     push;
   logic                     rd_enable;
   logic                     last_pop;
   logic [2:0]               pending;
   logic [DATA_WIDTH-1:0]    head_data;

   // Data only counts if this block requested it, so a stale rd_valid after reset is dropped.
   assign pop      = m_valid_reg && bus.m_ready_i;
   assign push     = bus.rd_valid_i && in_flight_reg;
   assign last_pop = pop && (words_left_reg == (ADDRESS_WIDTH+1)'(1));
   assign pending  = {1'b0, count_reg} + {2'b00, in_flight_reg} - {2'b00, pop};
   assign rd_enable = (state_reg == READ) && (pending < 3'd2);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      reads_left_next = reads_left_reg;
      words_left_next = words_left_reg - (ADDRESS_WIDTH+1)'(pop);
      done_next       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start_i) begin
               if (bus.length_i == '0) begin
                  done_next = 1'b1;
               end else begin
                  state_next      = READ;
                  addr_next       = bus.base_address_i;
                  reads_left_next = bus.length_i;
                  words_left_next = bus.length_i;
               end
            end
         end
         READ: begin
            if (rd_enable) begin
               addr_next       = addr_reg + 1'b1;
               reads_left_next = reads_left_reg - 1'b1;
               if (reads_left_reg == (ADDRESS_WIDTH+1)'(1)) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_pop) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      count_next   = count_reg + {1'b0, push} - {1'b0, pop};
      head_next    = head_reg ^ pop;
      tail_next    = tail_reg ^ push;
      m_valid_next = (count_next != 2'd0);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_reg       <= '0;
         reads_left_reg <= '0;
         words_left_reg <= '0;
         done_reg       <= 1'b0;
         in_flight_reg  <= 1'b0;
         count_reg      <= 2'd0;
         head_reg       <= 1'b0;
         tail_reg       <= 1'b0;
         m_valid_reg    <= 1'b0;
      end else begin
         addr_reg       <= addr_next;
         reads_left_reg <= reads_left_next;
         words_left_reg <= words_left_next;
         done_reg       <= done_next;
         in_flight_reg  <= rd_enable;
         count_reg      <= count_next;
         head_reg       <= head_next;
         tail_reg       <= tail_next;
         m_valid_reg    <= m_valid_next;
      end
   end

   // An occupied entry is never overwritten: the issue rule keeps count + in-flight within 2.
   for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
      logic [DATA_WIDTH-1:0] entry_reg;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            entry_reg <= '0;
         end else if (push && (tail_reg == 1'(gi))) begin
            entry_reg <= bus.rd_data_i;
         end
      end
   end

   assign head_data = head_reg ? gen_entry[1].entry_reg : gen_entry[0].entry_reg;

   assign bus.busy_o       = (state_reg != IDLE);
   assign bus.done_o       = done_reg;
   assign bus.rd_address_o = addr_reg;
   assign bus.rd_enable_o  = rd_enable;
   assign bus.m_data_o     = head_data;
   assign bus.m_valid_o    = m_valid_reg;
`ifdef BRAM_STREAM_READER_LAST_EN
   assign bus.m_last_o     = m_valid_reg && (words_left_reg == (ADDRESS_WIDTH+1)'(1));
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: RAM model, burst-level reference model, directed bursts.
// Builds with or without BRAM_STREAM_READER_LAST_EN.
module tb_bram_stream_reader;
   localparam int DW = 8;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic inject = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   burst_cycles = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   function automatic logic [7:0] ram_word(input logic [7:0] a);
      return a ^ 8'hA5;
   endfunction

   // RAM: one-cycle read latency; inject forces a spurious valid
   always @(posedge clk) begin
      if (!rst_n) begin
         bus.rd_valid_i <= 1'b0;
         bus.rd_data_i  <= '0;
      end else begin
         bus.rd_valid_i <= bus.rd_enable_o || inject;
         bus.rd_data_i  <= ram_word(bus.rd_address_o);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state
   logic       exp_busy = 1'b0;
   logic       exp_done = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] next_addr = '0;
   int         reads_left = 0;
   int         stream_left = 0;
   int         issued = 0;
   int         popped = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   int         start_cyc = 0;
   int         first_rd_cyc = -1;
   int         first_valid_cyc = -1;
   logic [7:0] first_data = '0;
   int         last_count = 0;

   always @(negedge clk) begin
      logic busy_now;
      logic xfer;
      if (!rst_n) begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         exp_q.delete();
         reads_left = 0;
         stream_left = 0;
         issued = 0;
         popped = 0;
         prev_stall = 1'b0;
      end else begin
         busy_now = exp_busy;
         xfer = bus.m_valid_o && bus.m_ready_i;
         check("busy", bus.busy_o, exp_busy);
         check("done", bus.done_o, exp_done);
         check("outstanding_le_2", (issued - popped) <= 2, 1);
         if (!busy_now) begin
            check("rd_idle", bus.rd_enable_o, 0);
            check("valid_idle", bus.m_valid_o, 0);
         end
         if (bus.rd_enable_o) begin
            check("rd_addr", bus.rd_address_o, next_addr);
            check("rd_in_burst", (reads_left > 0) && busy_now, 1);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
         end
         if (prev_stall) begin
            check("stall_valid", bus.m_valid_o, 1);
            check("stall_data", bus.m_data_o, prev_data);
         end
         if (bus.m_valid_o) begin
            if (first_valid_cyc < 0) begin
               first_valid_cyc = cyc;
               first_data = bus.m_data_o;
            end
`ifdef BRAM_STREAM_READER_LAST_EN
            check("m_last", bus.m_last_o, stream_left == 1);
            if (xfer && bus.m_last_o) last_count++;
`endif
         end
         if (xfer) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("data", bus.m_data_o, exp_q.pop_front());
         end
         prev_stall = bus.m_valid_o && !bus.m_ready_i;
         prev_data = bus.m_data_o;
         exp_done = 1'b0;
         if (bus.rd_enable_o && reads_left > 0) begin
            next_addr = next_addr + 8'd1;
            reads_left--;
            issued++;
         end
         if (xfer) begin
            popped++;
            stream_left--;
            if (stream_left == 0) begin
               check("all_reads_issued", reads_left, 0);
               exp_busy = 1'b0;
               exp_done = 1'b1;
            end
         end
         if (bus.start_i && !busy_now) begin
            start_cyc = cyc;
            first_rd_cyc = -1;
            first_valid_cyc = -1;
            last_count = 0;
            if (bus.length_i == 0) begin
               exp_done = 1'b1;
            end else begin
               exp_busy = 1'b1;
               next_addr = bus.base_address_i;
               reads_left = int'(bus.length_i);
               stream_left = int'(bus.length_i);
               issued = 0;
               popped = 0;
               exp_q.delete();
               for (int k = 0; k < int'(bus.length_i); k++)
                  exp_q.push_back(ram_word(bus.base_address_i + 8'(k)));
            end
         end
      end
   end

   task automatic run_burst(input logic [7:0] base, input logic [8:0] len,
                            input bit toggle, input bit intrude);
      bit ok;
      int s_cyc;
      ok = 1'b0;
      s_cyc = cyc;
      bus.start_i = 1'b1;
      bus.base_address_i = base;
      bus.length_i = len;
      bus.m_ready_i = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         bus.start_i = 1'b0;
         if (intrude && i == 1) begin
            bus.start_i = 1'b1;
            bus.base_address_i = 8'h80;
            bus.length_i = 9'd3;
         end
         bus.m_ready_i = toggle ? (i % 2 == 1) : 1'b1;
         if (bus.done_o) begin
            ok = 1'b1;
            burst_cycles = cyc - s_cyc;
            break;
         end
      end
      if (!ok) check("burst_timeout", 0, 1);
      bus.m_ready_i = 1'b1;
      $display("[TB] burst base=%0h len=%0d toggle=%0d intrude=%0d cycles=%0d", base, len, toggle, intrude, burst_cycles);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start_i = 1'b0;
      bus.base_address_i = '0;
      bus.length_i = '0;
      bus.m_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_rd_en", bus.rd_enable_o, 0);
      check("rst_rd_addr", bus.rd_address_o, 0);
      check("rst_valid", bus.m_valid_o, 0);
      check("rst_data", bus.m_data_o, 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_burst(8'h10, 9'd4, 1'b0, 1'b0);
      check("lat_rd", first_rd_cyc - start_cyc, 1);
      check("lat_valid", first_valid_cyc - start_cyc, 3);
      check("lat_done", burst_cycles, 7);
      check("first_data", first_data, 8'hB5);

      run_burst(8'hFE, 9'd4, 1'b0, 1'b0);
      check("wrap_first_data", first_data, 8'h5B);

      run_burst(8'h30, 9'd8, 1'b1, 1'b0);

      run_burst(8'h00, 9'd0, 1'b0, 1'b0);
      check("len0_done_lat", burst_cycles, 1);
      check("len0_no_read", first_rd_cyc, -1);

      run_burst(8'h50, 9'd6, 1'b0, 1'b1);
      check("intrude_len", burst_cycles, 9);

      // Reset in cycle 3 of a 16-word burst
      bus.start_i = 1'b1;
      bus.base_address_i = 8'h40;
      bus.length_i = 9'd16;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus.start_i = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy_o, 0);
      check("abort_done", bus.done_o, 0);
      check("abort_rd_en", bus.rd_enable_o, 0);
      check("abort_rd_addr", bus.rd_address_o, 0);
      check("abort_valid", bus.m_valid_o, 0);
      check("abort_data", bus.m_data_o, 0);
      $display("[TB] reset asserted mid-burst at cycle %0d", cyc);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
      inject = 1'b1;
      @(posedge clk); #1;
      inject = 1'b0;
      @(posedge clk); #1;
      check("stale_valid_dropped", bus.m_valid_o, 0);
      check("no_done_after_abort", bus.done_o, 0);
      run_burst(8'h20, 9'd6, 1'b0, 1'b0);
      check("post_reset_first_data", first_data, 8'h85);

      run_burst(8'h33, 9'd256, 1'b0, 1'b0);
      check("max_burst_len", burst_cycles, 259);

      run_burst(8'h60, 9'd5, 1'b1, 1'b0);
`ifdef BRAM_STREAM_READER_LAST_EN
      check("last_count", last_count, 1);
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
